// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion scheduler.
package a2d_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } sched_state_t;

   typedef logic [11:0] a2d_res_t;

   // Board wiring order of the IR line sensors onto A2D channels.
   localparam logic [2:0] SNS_CHNL_MAP [0:7] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7, 3'd6, 3'd5};

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module gap_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin A2D scheduler: sweeps the line sensors on go and slots in
// battery conversions between sensor conversions.
module a2d_rr_sched
   import a2d_pkg::*;
#(
   parameter int         NUM_SNS  = 6,
   parameter int         GAP_CYC  = 4,
   parameter logic [2:0] BAT_CHNL = 3'd5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   go,
   input  logic                   bat_req,
   input  logic                   cnv_cmplt,
   input  a2d_res_t               res,
   output logic                   strt_cnv,
   output logic [2:0]             chnnl,
   output logic [12*NUM_SNS-1:0]  sns_flat,
   output logic                   rnd_vld,
   output logic                   bat_ack,
   output a2d_res_t               bat_val,
   output logic                   busy,
   output sched_state_t           dbg_state
);

   localparam int         GW       = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
   localparam logic [2:0] LAST_IDX = 3'(NUM_SNS - 1);

   sched_state_t state, state_n;
   logic [2:0]   idx;
   logic         rnd_act;
   logic         job_bat;
   logic         cnv_d;
   logic         cmplt_rise;
   logic         gap_done;
   logic         arb;
   logic         pick_bat, pick_cont, pick_new;
   logic         latch;

   assign cmplt_rise = cnv_cmplt & ~cnv_d;

   gap_timer #(.W(GW)) u_gap (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (latch),
      .load_val (GW'(GAP_CYC)),
      .done     (gap_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Battery first so it lands between sensor slots; then finish the round; then a new one.
   always_comb begin
      state_n   = state;
      arb       = 1'b0;
      pick_bat  = 1'b0;
      pick_cont = 1'b0;
      pick_new  = 1'b0;
      latch     = 1'b0;
      case (state)
         IDLE:  arb = 1'b1;
         START: state_n = WAIT;
         WAIT: begin
            if (cmplt_rise) begin
               latch   = 1'b1;
               state_n = GAP;
            end
         end
         GAP:   arb = gap_done;
         default: state_n = IDLE;
      endcase
      if (arb) begin
         if (bat_req)      pick_bat  = 1'b1;
         else if (rnd_act) pick_cont = 1'b1;
         else if (go)      pick_new  = 1'b1;
         state_n = (pick_bat | pick_cont | pick_new) ? START : IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnv_d    <= 1'b0;
         idx      <= 3'd0;
         rnd_act  <= 1'b0;
         job_bat  <= 1'b0;
         chnnl    <= 3'd0;
         sns_flat <= '0;
         rnd_vld  <= 1'b0;
         bat_ack  <= 1'b0;
         bat_val  <= '0;
      end else begin
         cnv_d   <= cnv_cmplt;
         rnd_vld <= 1'b0;
         bat_ack <= 1'b0;
         if (pick_bat) begin
            job_bat <= 1'b1;
            chnnl   <= BAT_CHNL;
         end
         if (pick_cont) begin
            job_bat <= 1'b0;
            chnnl   <= SNS_CHNL_MAP[idx];
         end
         if (pick_new) begin
            job_bat <= 1'b0;
            rnd_act <= 1'b1;
            idx     <= 3'd0;
            chnnl   <= SNS_CHNL_MAP[0];
         end
         if (latch && job_bat) begin
            bat_val <= res;
            bat_ack <= 1'b1;
         end
         if (latch && !job_bat) begin
            if (idx == LAST_IDX) begin
               idx     <= 3'd0;
               rnd_act <= 1'b0;
               rnd_vld <= 1'b1;
            end else begin
               idx <= idx + 3'd1;
            end
         end
         for (int i = 0; i < NUM_SNS; i++) begin
            if (latch && !job_bat && idx == 3'(i)) sns_flat[i*12 +: 12] <= res;
         end
      end
   end

   assign strt_cnv  = (state == START);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Bench for a2d_rr_sched: A2D responder, timeline model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_a2d_rr_sched;
   import a2d_pkg::*;

   localparam int         NUM_SNS  = 6;
   localparam int         GAP_CYC  = 4;
   localparam logic [2:0] BAT_CHNL = 3'd5;
   localparam int         FW       = 12 * NUM_SNS;

   // clock / reset and DUT
   logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, bat_req = 1'b0, cnv_cmplt = 1'b0;
   logic [11:0] res = 12'd0;
   logic strt_cnv, rnd_vld, bat_ack, busy;
   logic [2:0] chnnl;
   logic [FW-1:0] sns_flat;
   logic [11:0] bat_val;
   sched_state_t dbg_state;

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   a2d_rr_sched #(.NUM_SNS(NUM_SNS), .GAP_CYC(GAP_CYC), .BAT_CHNL(BAT_CHNL)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .bat_req(bat_req), .cnv_cmplt(cnv_cmplt),
      .res(res), .strt_cnv(strt_cnv), .chnnl(chnnl), .sns_flat(sns_flat),
      .rnd_vld(rnd_vld), .bat_ack(bat_ack), .bat_val(bat_val), .busy(busy),
      .dbg_state(dbg_state)
   );

   int n_checks = 0, n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Behavioural model: timeline of decision points and conversions
   int unsigned map_tab [8] = '{1, 0, 4, 2, 3, 7, 6, 5};
   int   m_mode;     // 0 idle, 1 converting, 2 spacing after a result
   int   m_idx, m_start, m_decide;
   bit   m_rnd, m_job_bat, m_prev;
   logic [11:0] m_bank [NUM_SNS];
   logic [11:0] e_bat;
   logic [2:0]  e_chnnl;
   bit   e_strt, e_rv, e_ba, e_busy;

   task automatic model_reset();
      m_mode = 0; m_idx = 0; m_start = 0; m_decide = 0;
      m_rnd = 0; m_job_bat = 0; m_prev = 0;
      for (int i = 0; i < NUM_SNS; i++) m_bank[i] = 12'd0;
      e_bat = 12'd0; e_chnnl = 3'd0;
      e_strt = 0; e_rv = 0; e_ba = 0; e_busy = 0;
   endtask

   function automatic logic [FW-1:0] model_flat();
      logic [FW-1:0] f;
      for (int i = 0; i < NUM_SNS; i++) f[i*12 +: 12] = m_bank[i];
      return f;
   endfunction

   task automatic launch();
      e_strt  = 1;
      m_mode  = 1;
      m_start = cyc + 1;
   endtask

   // Advance the model from the inputs of the current cycle to the next cycle.
   task automatic model_step();
      bit rise, decide;
      e_strt = 0; e_rv = 0; e_ba = 0;
      rise   = cnv_cmplt && !m_prev;
      m_prev = cnv_cmplt;
      decide = 0;
      if (m_mode == 0) decide = 1;
      else if (m_mode == 2) decide = (cyc == m_decide);
      else if (cyc > m_start && rise) begin
         if (m_job_bat) begin
            e_bat = res;
            e_ba  = 1;
         end else begin
            m_bank[m_idx] = res;
            if (m_idx == NUM_SNS - 1) begin
               e_rv = 1; m_idx = 0; m_rnd = 0;
            end else m_idx++;
         end
         m_mode   = 2;
         m_decide = cyc + 1 + GAP_CYC;
      end
      if (decide) begin
         if (bat_req) begin
            m_job_bat = 1; e_chnnl = BAT_CHNL; launch();
         end else if (m_rnd) begin
            m_job_bat = 0; e_chnnl = 3'(map_tab[m_idx]); launch();
         end else if (go) begin
            m_job_bat = 0; m_rnd = 1; m_idx = 0; e_chnnl = 3'(map_tab[0]); launch();
         end else m_mode = 0;
      end
      e_busy = (m_mode != 0);
   endtask

   // Compare process
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_reset();
            check("rst_strt_cnv", strt_cnv, 0);
            check("rst_chnnl", chnnl, 0);
            check("rst_sns_flat", sns_flat, 0);
            check("rst_rnd_vld", rnd_vld, 0);
            check("rst_bat_ack", bat_ack, 0);
            check("rst_bat_val", bat_val, 0);
            check("rst_busy", busy, 0);
         end else begin
            check("strt_cnv", strt_cnv, e_strt);
            check("chnnl", chnnl, e_chnnl);
            check("sns_flat", sns_flat, model_flat());
            check("rnd_vld", rnd_vld, e_rv);
            check("bat_ack", bat_ack, e_ba);
            check("bat_val", bat_val, e_bat);
            check("busy", busy, e_busy);
            model_step();
         end
      end
   end

   // A2D responder and event log
   bit rand_mode = 0, stuck_mode = 0;
   int fixed_delay = 40, stuck_hold = 6;
   int resp_cnt = 0, low_cnt = 0;
   logic [11:0] resp_val = 12'd0;
   int ch_log[$], strt_cyc_q[$], rv_cyc_q[$];
   int start_cnt = 0, ba_cnt = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            resp_cnt = 0; low_cnt = 0; cnv_cmplt = 1'b0;
         end else begin
            if (rnd_vld) rv_cyc_q.push_back(cyc);
            if (bat_ack) ba_cnt++;
            if (strt_cnv) begin
               start_cnt++;
               ch_log.push_back(int'(chnnl));
               strt_cyc_q.push_back(cyc);
               if (rand_mode) resp_val = 12'($urandom);
               else if (chnnl == 3'd5) resp_val = 12'hABC;
               else resp_val = 12'h100 + {9'd0, chnnl};
               if (rand_mode) begin
                  resp_cnt = $urandom_range(40, 3);
                  if ($urandom_range(7, 0) == 0) low_cnt = $urandom_range(resp_cnt - 1, 1);
                  else begin low_cnt = 0; cnv_cmplt = 1'b0; end
               end else begin
                  resp_cnt = fixed_delay;
                  if (stuck_mode) low_cnt = stuck_hold;
                  else begin low_cnt = 0; cnv_cmplt = 1'b0; end
               end
            end else if (resp_cnt > 0) begin
               resp_cnt--;
               if (low_cnt > 0) begin
                  low_cnt--;
                  if (low_cnt == 0) cnv_cmplt = 1'b0;
               end
               if (resp_cnt == 0) begin
                  cnv_cmplt = 1'b1;
                  res = resp_val;
               end
            end
         end
      end
   end

   function automatic int log_at(input int i);
      return (i < ch_log.size()) ? ch_log[i] : -1;
   endfunction

   task automatic clear_logs();
      ch_log.delete(); strt_cyc_q.delete(); rv_cyc_q.delete();
      start_cnt = 0; ba_cnt = 0;
   endtask

   task automatic wait_log(input int n, input int lim);
      int k = 0;
      while (ch_log.size() < n && k < lim) begin tick(); k++; end
      check("wait_strt_cnv", ch_log.size() >= n, 1);
   endtask

   task automatic wait_rv(input int n, input int lim);
      int k = 0;
      while (rv_cyc_q.size() < n && k < lim) begin tick(); k++; end
      check("wait_rnd_vld", rv_cyc_q.size() >= n, 1);
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (busy && k < lim) begin tick(); k++; end
      check("wait_idle", busy, 0);
   endtask

   task automatic pulse_go();
      go = 1'b1; tick(); go = 1'b0;
   endtask

   logic [2:0] exp_q[$];
   int go_hold = 0;

   initial begin
      int k, rv1, nxt, lat;
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // single round
      clear_logs();
      pulse_go();
      wait_rv(1, 1000);
      wait_idle(100);
      exp_q = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
      check("round_len", ch_log.size(), 6);
      for (int i = 0; i < 6; i++) check("round_order", log_at(i), int'(exp_q.pop_front()));
      check("sns0", sns_flat[11:0], 12'h101);
      check("sns5", sns_flat[71:60], 12'h107);
      check("round_rv_cnt", rv_cyc_q.size(), 1);

      // battery mid-round
      clear_logs();
      pulse_go();
      wait_log(3, 200);
      tick(2);
      bat_req = 1'b1;
      k = 0;
      while (!bat_ack && k < 500) begin tick(); k++; end
      check("bat_ack_seen", bat_ack, 1);
      bat_req = 1'b0;
      check("bat_val_abc", bat_val, 12'hABC);
      wait_rv(1, 1000);
      wait_idle(100);
      check("bat_slot_chnl", log_at(3), 5);
      check("bat_resume_chnl", log_at(4), 2);
      check("bat_strt_total", start_cnt, 7);
      check("bat_ack_cnt", ba_cnt, 1);

      // held go
      clear_logs();
      go = 1'b1;
      wait_rv(2, 2000);
      go = 1'b0;
      wait_idle(100);
      check("held_rv_cnt", rv_cyc_q.size(), 2);
      check("held_strt_cnt", start_cnt, 12);
      rv1 = (rv_cyc_q.size() > 0) ? rv_cyc_q[0] : 0;
      nxt = -1;
      foreach (strt_cyc_q[i]) if (nxt < 0 && strt_cyc_q[i] > rv1) nxt = strt_cyc_q[i];
      check("held_gap", nxt - rv1, GAP_CYC + 1);

      // reset mid-round
      clear_logs();
      pulse_go();
      wait_log(4, 400);
      tick(3);
      rst_n = 1'b0;
      #2;
      check("amid_rst_sns", sns_flat, 0);
      check("amid_rst_state", dbg_state, IDLE);
      check("amid_rst_busy", busy, 0);
      tick(2);
      rst_n = 1'b1;
      start_cnt = 0;
      tick(20);
      check("post_rst_strt", start_cnt, 0);
      check("post_rst_state", dbg_state, IDLE);

      // cnv_cmplt stuck high on entry to WAIT
      clear_logs();
      stuck_mode = 1; fixed_delay = 12; stuck_hold = 6;
      cnv_cmplt = 1'b1; res = 12'hFFF;
      pulse_go();
      wait_log(1, 50);
      k = 0;
      while (sns_flat[11:0] == 12'd0 && k < 100) begin tick(); k++; end
      lat = cyc;
      stuck_mode = 0;
      check("stuck_latch_delay", lat - ((strt_cyc_q.size() > 0) ? strt_cyc_q[0] : 0), 13);
      check("stuck_sns0", sns_flat[11:0], 12'h101);
      wait_rv(1, 1000);
      wait_idle(100);

      // go and bat_req together from IDLE
      clear_logs();
      go = 1'b1; bat_req = 1'b1;
      k = 0;
      while ((go || bat_req) && k < 600) begin
         tick(); k++;
         if (bat_ack) bat_req = 1'b0;
         if (ch_log.size() >= 2) go = 1'b0;
      end
      check("simul_done", go | bat_req, 0);
      go = 1'b0; bat_req = 1'b0;
      wait_rv(1, 1000);
      wait_idle(100);
      check("simul_first", log_at(0), 5);
      check("simul_second", log_at(1), 1);
      check("simul_bat_val", bat_val, 12'hABC);

      // randomized traffic
      rand_mode = 1;
      repeat (3000) begin
         tick();
         if (go_hold > 0) begin
            go_hold--;
            if (go_hold == 0) go = 1'b0;
         end else if ($urandom_range(24, 0) == 0) begin
            go = 1'b1; go_hold = $urandom_range(30, 1);
         end
         if (bat_req) begin
            if (bat_ack) bat_req = 1'b0;
         end else if ($urandom_range(59, 0) == 0) bat_req = 1'b1;
      end
      go = 1'b0;
      k = 0;
      while ((bat_req || busy) && k < 2000) begin
         tick(); k++;
         if (bat_req && bat_ack) bat_req = 1'b0;
      end
      check("drain_idle", bat_req | busy, 0);
      tick(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
